drum_strike_sequencer: RTL

Parametrised excitation scheduler for the drum synthesis core. It divides `CLOCK_50` down to an audio sample strobe and keeps a running sample index. For each of `NUM_CH` drum channels it issues strike requests, carrying a latched amplitude, either periodically or once. Each request is held on a valid/ready handshake until the solver accepts it. It replaces fixed clock/reset/index stimulus with a synthesizable, multi-channel source usable on the board and in simulation.

---
 rtl/drum_strike_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/drum_strike_sequencer.sv
// rtl/drum_strike_sequencer.sv - multi-channel strike request scheduler
// Divides the clock to a sample strobe and issues per-channel strike requests on valid/ready.
module drum_strike_sequencer #(
   parameter int CLK_DIV  = 1042,
   parameter int NUM_CH   = 4,
   parameter int IDX_W    = 32,
   parameter int PERIOD_W = 16,
   parameter int AMP_W    = 18
) (
   input  logic                         CLOCK_50,
   input  logic                         reset,
   input  logic                         enable,
   input  logic                         mode,
   input  logic [NUM_CH*PERIOD_W-1:0]   period,
   input  logic [NUM_CH*AMP_W-1:0]      amp_in,
   output logic                         sample_tick,
   output logic [IDX_W-1:0]             sample_index,
   output logic [NUM_CH-1:0]            strike_valid,
   input  logic [NUM_CH-1:0]            strike_ready,
   output logic [NUM_CH*AMP_W-1:0]      strike_amp,
   output logic [NUM_CH*8-1:0]          missed,
   output logic                         busy
);

   localparam int DIV_W = $clog2(CLK_DIV);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state, next_state;
   logic [DIV_W-1:0]   div;
   logic               one_shot;
   logic               start, running, tick_now;
   logic [NUM_CH-1:0]  chan_done;

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (enable) next_state = RUN;
         RUN: begin
            if (!enable)
               next_state = IDLE;
            else if (one_shot && (&chan_done) && (strike_valid == '0))
               next_state = DONE;
         end
         DONE: if (!enable) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      start    = (state == IDLE) && enable;
      running  = (state == RUN) && enable;
      tick_now = running && (div == DIV_W'(CLK_DIV - 1));
   end

   // DONE freezes divider and index; every other non-running cycle clears them.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         div          <= '0;
         sample_tick  <= 1'b0;
         sample_index <= '0;
         busy         <= 1'b0;
         one_shot     <= 1'b0;
      end else begin
         busy        <= (next_state == RUN);
         sample_tick <= tick_now;
         if (start) begin
            one_shot     <= mode;
            div          <= '0;
            sample_index <= '0;
         end else if (running) begin
            div <= tick_now ? '0 : div + DIV_W'(1);
            if (tick_now) sample_index <= sample_index + IDX_W'(1);
         end else if (state != DONE) begin
            div          <= '0;
            sample_index <= '0;
         end
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [PERIOD_W-1:0] per, cd;
      logic [AMP_W-1:0]    amp;
      logic [7:0]          miss;
      logic                valid, struck, strike, xfer;

      assign per    = period[c*PERIOD_W +: PERIOD_W];
      assign strike = tick_now && (cd == '0) && (per != '0) && !(one_shot && struck);
      assign xfer   = valid && strike_ready[c];

      assign chan_done[c]              = (per == '0) || struck;
      assign strike_valid[c]           = valid;
      assign strike_amp[c*AMP_W +: AMP_W] = amp;
      assign missed[c*8 +: 8]          = miss;

      always_ff @(posedge CLOCK_50 or negedge reset) begin
         if (!reset) begin
            cd     <= '0;
            amp    <= '0;
            miss   <= '0;
            valid  <= 1'b0;
            struck <= 1'b0;
         end else if (start) begin
            cd     <= '0;
            miss   <= '0;
            valid  <= 1'b0;
            struck <= 1'b0;
         end else if (!running) begin
            cd    <= '0;
            valid <= 1'b0;
         end else begin
            if (strike && !one_shot)
               cd <= per - PERIOD_W'(1);
            else if (tick_now && (cd != '0))
               cd <= cd - PERIOD_W'(1);
            if (strike && one_shot) struck <= 1'b1;
            // A strike landing on an accept cycle replaces the request rather than counting a miss.
            if (strike) begin
               valid <= 1'b1;
               if (!valid || xfer)
                  amp <= amp_in[c*AMP_W +: AMP_W];
               else if (miss != 8'hFF)
                  miss <= miss + 8'd1;
            end else if (xfer) begin
               valid <= 1'b0;
            end
         end
      end
   end

endmodule
